// File: rtl/pipelined_carry_skip_add.sv
// pipelined_carry_skip_add: valid/ready pipelined carry-skip adder/subtractor with carry, overflow and zero flags.
// Each register stage resolves GPS skip groups; operands travel with the transaction and finished sum bits are carried along.
module pipelined_carry_skip_add #(
    parameter int N      = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         co,
    output logic         ov,
    output logic         zero
);
    localparam int G   = N / BLOCK;
    localparam int GPS = G / STAGES;
    localparam int W   = $clog2(N);

    if (N % BLOCK != 0 || STAGES < 1 || STAGES > G || G % STAGES != 0) begin : g_bad
        $fatal(1, "pipelined_carry_skip_add: illegal N/BLOCK/STAGES combination");
    end

    logic         w_adv;
    logic         w_v  [STAGES];
    logic [N-1:0] w_a  [STAGES];
    logic [N-1:0] w_b  [STAGES];
    logic [N-1:0] w_s  [STAGES];
    logic         w_cy [STAGES];
    logic [N-1:0] w_ns [STAGES];
    logic         w_ncy[STAGES];
    logic         w_cm [STAGES];
    logic         r_v  [STAGES];
    logic [N-1:0] r_a  [STAGES];
    logic [N-1:0] r_b  [STAGES];
    logic [N-1:0] r_s  [STAGES];
    logic         r_cy [STAGES];
    logic         r_ov;
    logic         r_z;

    assign w_adv     = !r_v[STAGES-1] | out_ready;
    assign in_ready  = w_adv;
    assign w_v[0]    = in_valid;
    assign w_a[0]    = a;
    assign w_b[0]    = sub ? ~b : b;
    assign w_cy[0]   = ci;
    assign w_s[0]    = '0;

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        logic [N-1:0] l_s;
        logic [W-1:0] l_i;
        logic         l_cy, l_cm, l_gc, l_p, l_x;
        always_comb begin
            l_s  = w_s[s];
            l_cy = w_cy[s];
            l_cm = 1'b0;
            l_gc = 1'b0;
            l_p  = 1'b0;
            l_x  = 1'b0;
            l_i  = '0;
            for (int g = 0; g < GPS; g++) begin
                l_gc = l_cy;
                l_p  = 1'b1;
                for (int k = 0; k < BLOCK; k++) begin
                    l_i      = W'((s * GPS + g) * BLOCK + k);
                    l_x      = w_a[s][l_i] ^ w_b[s][l_i];
                    l_s[l_i] = l_x ^ l_gc;
                    l_cm     = (l_i == W'(N - 1)) ? l_gc : l_cm;
                    l_gc     = (w_a[s][l_i] & w_b[s][l_i]) | (l_x & l_gc);
                    l_p      = l_p & l_x;
                end
                // skip mux: a fully propagating group forwards its carry-in directly
                l_cy = l_p ? l_cy : l_gc;
            end
        end
        assign w_ns[s]  = l_s;
        assign w_ncy[s] = l_cy;
        assign w_cm[s]  = l_cm;
        if (s < STAGES - 1) begin : g_nx
            assign w_v[s+1]  = r_v[s];
            assign w_a[s+1]  = r_a[s];
            assign w_b[s+1]  = r_b[s];
            assign w_s[s+1]  = r_s[s];
            assign w_cy[s+1] = r_cy[s];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i]  <= 1'b0;
                r_a[i]  <= '0;
                r_b[i]  <= '0;
                r_s[i]  <= '0;
                r_cy[i] <= 1'b0;
            end
            r_ov <= 1'b0;
            r_z  <= 1'b0;
        end else if (w_adv) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i]  <= w_v[i];
                r_a[i]  <= w_a[i];
                r_b[i]  <= w_b[i];
                r_s[i]  <= w_ns[i];
                r_cy[i] <= w_ncy[i];
            end
            r_ov <= w_cm[STAGES-1] ^ w_ncy[STAGES-1];
            r_z  <= ~|w_ns[STAGES-1];
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign c         = r_s[STAGES-1];
    assign co        = r_cy[STAGES-1];
    assign ov        = r_ov;
    assign zero      = r_z;
endmodule

// File: tb/tb_pipelined_carry_skip_add.sv
// tb_pipelined_carry_skip_add: directed checks on a 32-bit/2-stage instance plus randomized
// scoreboard runs on 16-bit instances with 1, 2 and 4 stages against an arithmetic model.
module tb_pipelined_carry_skip_add;
    localparam int NT = 10000;

    logic clk, rst_n;
    int total = 0, bad = 0;

    logic        m_iv, m_ir, m_ovl, m_or, m_ci, m_sub, m_co, m_ovf, m_z;
    logic [31:0] m_a, m_b, m_c;

    logic        s_iv[3], s_ir[3], s_ovl[3], s_or[3], s_ci[3], s_sub[3], s_co[3], s_ovf[3], s_z[3];
    logic [15:0] s_a[3], s_b[3], s_c[3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pipelined_carry_skip_add #(.N(32), .BLOCK(4), .STAGES(2)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
        .ci(m_ci), .sub(m_sub), .out_valid(m_ovl), .out_ready(m_or), .c(m_c),
        .co(m_co), .ov(m_ovf), .zero(m_z)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        pipelined_carry_skip_add #(.N(16), .BLOCK(4), .STAGES(g == 0 ? 1 : g == 1 ? 2 : 4)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(s_iv[g]), .in_ready(s_ir[g]), .a(s_a[g]), .b(s_b[g]),
            .ci(s_ci[g]), .sub(s_sub[g]), .out_valid(s_ovl[g]), .out_ready(s_or[g]), .c(s_c[g]),
            .co(s_co[g]), .ov(s_ovf[g]), .zero(s_z[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int stg(input int d);
        return d == 0 ? 1 : d == 1 ? 2 : 4;
    endfunction

    function automatic logic [18:0] mdl(input logic [15:0] x, y, input logic cin, sb);
        logic [15:0] yy;
        logic [16:0] s;
        logic        v;
        yy = sb ? ~y : y;
        s  = 17'(x) + 17'(yy) + 17'(cin);
        v  = (x[15] == yy[15]) && (s[15] != x[15]);
        return {s[16], v, s[15:0] == 16'd0, s[15:0]};
    endfunction

    task automatic drv(input logic [31:0] x, y, input logic cin, sb);
        m_a = x; m_b = y; m_ci = cin; m_sub = sb; m_iv = 1'b1;
    endtask

    logic [63:0] q[3][$];

    initial begin
        int          nx, k, stall, sent[3];
        logic        prev_or, done, p_v[3], p_or[3];
        logic [31:0] prev_c;
        logic [19:0] p_o[3], obs;
        logic [63:0] e;

        rst_n = 1'b0; m_or = 1'b1;
        drv(32'h1234, 32'h5678, 1'b1, 1'b0);
        for (int d = 0; d < 3; d++) begin
            s_iv[d] = 1'b0; s_or[d] = 1'b1; s_a[d] = '0; s_b[d] = '0; s_ci[d] = 1'b0; s_sub[d] = 1'b0;
            sent[d] = 0; p_v[d] = 1'b0; p_or[d] = 1'b1; p_o[d] = '0;
        end

        // reset held for three edges with a valid input present
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", m_ovl, 0);
        chk("rst_c", m_c, 0);
        chk("rst_co", m_co, 0);
        chk("rst_ov", m_ovf, 0);
        chk("rst_zero", m_z, 0);
        rst_n = 1'b1; m_iv = 1'b0;
        #1 chk("rst_ready", m_ir, 1);

        // full-propagate: carry-in skips every group and stage
        @(negedge clk) drv(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        @(negedge clk) m_iv = 1'b0;
        #1 chk("fp_early", m_ovl, 0);
        @(negedge clk);
        #1;
        chk("fp_valid", m_ovl, 1);
        chk("fp_c", m_c, 32'h0);
        chk("fp_co", m_co, 1);
        chk("fp_zero", m_z, 1);
        chk("fp_ov", m_ovf, 0);

        // subtraction, one overflowing and one negative result, back to back
        @(negedge clk) drv(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        @(negedge clk) drv(32'h5, 32'h7, 1'b1, 1'b1);
        @(negedge clk) m_iv = 1'b0;
        #1;
        chk("sub1_valid", m_ovl, 1);
        chk("sub1_c", m_c, 32'h7FFF_FFFF);
        chk("sub1_co", m_co, 1);
        chk("sub1_ov", m_ovf, 1);
        chk("sub1_zero", m_z, 0);
        @(negedge clk);
        #1;
        chk("sub2_valid", m_ovl, 1);
        chk("sub2_c", m_c, 32'hFFFF_FFFE);
        chk("sub2_co", m_co, 0);
        chk("sub2_ov", m_ovf, 0);

        // backpressure: eight back-to-back sums, 5-cycle stall after the first result
        nx = 0; k = 0; stall = 0; prev_or = 1'b1; prev_c = '0;
        for (int cy = 0; cy < 40 && k < 8; cy++) begin
            @(negedge clk);
            m_or = (stall <= 0);
            m_iv = (nx < 8); m_a = 32'(nx); m_b = 32'(nx * 16); m_ci = 1'b0; m_sub = 1'b0;
            #1;
            if (stall > 0) stall--;
            if (!m_or) begin
                chk("bp_ready", m_ir, 0);
                chk("bp_valid", m_ovl, 1);
                if (!prev_or) chk("bp_hold", m_c, prev_c);
            end
            if (m_ovl && m_or) begin
                chk("bp_data", m_c, 32'(k * 17));
                if (k == 0) stall = 5;
                k++;
            end
            if (m_iv && m_ir) nx++;
            prev_or = m_or; prev_c = m_c;
        end
        chk("bp_count", 64'(k), 8);
        m_iv = 1'b0; m_or = 1'b1;
        @(negedge clk);
        #1 chk("bp_empty", m_ovl, 0);

        // reset with two transactions in flight and none handed over
        @(negedge clk) drv(32'h1, 32'h1, 1'b0, 1'b0);
        @(negedge clk) begin m_or = 1'b0; drv(32'h2, 32'h2, 1'b0, 1'b0); end
        @(negedge clk) begin m_iv = 1'b0; rst_n = 1'b0; end
        @(negedge clk) begin rst_n = 1'b1; m_or = 1'b1; end
        #1 chk("mid_rst_valid", m_ovl, 0);
        repeat (6) begin
            @(negedge clk);
            #1 chk("mid_rst_none", m_ovl, 0);
        end

        // random sweep on N=16 with 1/2/4 stages; unstalled first to measure latency
        for (int cy = 0; cy < 40000; cy++) begin
            done = 1'b1;
            for (int d = 0; d < 3; d++) if (sent[d] != NT || q[d].size() != 0) done = 1'b0;
            if (cy >= 200 && done) break;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                s_or[d]  = (cy < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_iv[d]  = (sent[d] < NT) && ($urandom_range(0, 3) != 0);
                s_a[d]   = 16'($urandom);
                s_b[d]   = 16'($urandom);
                s_ci[d]  = 1'($urandom_range(0, 1));
                s_sub[d] = 1'($urandom_range(0, 1));
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                obs = {s_ovl[d], s_co[d], s_ovf[d], s_z[d], s_c[d]};
                if (p_v[d] && !p_or[d]) chk("sw_hold", 64'(obs), 64'(p_o[d]));
                if (s_iv[d] && s_ir[d]) begin
                    q[d].push_back({32'(cy), 13'd0, mdl(s_a[d], s_b[d], s_ci[d], s_sub[d])});
                    sent[d]++;
                end
                if (s_ovl[d] && s_or[d]) begin
                    if (q[d].size() == 0) chk("sw_extra", 64'(s_ovl[d]), 0);
                    else begin
                        e = q[d].pop_front();
                        chk("sw_data", 64'(obs[18:0]), 64'(e[18:0]));
                        if (cy < 200) chk("sw_latency", 64'(cy - int'(e[63:32])), 64'(stg(d)));
                    end
                end
                p_v[d] = s_ovl[d]; p_or[d] = s_or[d]; p_o[d] = obs;
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk("sw_sent", 64'(sent[d]), 64'(NT));
            chk("sw_drain", 64'(q[d].size()), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_carry_skip_add.md
Name: pipelined_carry_skip_add

Overview:
Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface on both sides. Operands are split into BLOCK-bit skip groups. The groups are spread evenly across STAGES register stages, and the inter-stage carry is registered. It is the sequential successor of the combinational carry-skip adder in the FixedPointArithmetic Add unit, for datapaths where the full-width skip chain misses timing. It adds per-transaction add/subtract mode and status flags.

Parameters:
N, 32, datapath width in bits.
BLOCK, 4, skip-group width in bits; N % BLOCK == 0 is required.
STAGES, 2, number of pipeline register stages (latency); 1 <= STAGES <= N/BLOCK and (N/BLOCK) % STAGES == 0 are required.
Any constraint violation is an elaboration-time fatal error.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  operand transaction valid.
in_ready  out  1  block can accept a transaction this cycle.
a  in  N  operand A.
b  in  N  operand B.
ci  in  1  carry in (borrow-not-in when sub=1).
sub  in  1  0: c = a + b + ci; 1: c = a + ~b + ci.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
c  out  N  result sum/difference.
co  out  1  carry out of bit N-1.
ov  out  1  two's-complement signed overflow.
zero  out  1  c == 0.

Behaviour:
- Reset (rst_n=0 at a clock edge): all stage valid bits cleared; out_valid=0; c, co, ov, zero=0. in_ready=1 in the first cycle after reset if out_ready is ignored, since the pipeline is empty.
- Reset mid-operation drops all in-flight transactions. No result emerges for them.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational from out_ready.
- A transaction is accepted when in_valid & in_ready. An output handshake occurs when out_valid & out_ready.
- When adv=1, every stage register loads from the previous stage and stage-0 loads the input. A bubble is inserted if in_valid=0.
- When adv=0, every stage register holds, including the data of invalid stages.
- Latency: a transaction accepted at edge k has out_valid=1 after edge k+STAGES-1+1. That is, it is visible STAGES cycles after acceptance, assuming no stalls.
- Throughput: one transaction per cycle while out_ready=1.
- Ordering is strictly preserved. No transaction is lost or duplicated under any out_ready pattern.
- Operand preparation at stage 0: bb = sub ? ~b : b; the group carry-in is ci.
- G = N/BLOCK groups; each stage processes G/STAGES consecutive groups, LSB groups first.
- Per group:
  - ripple sum of BLOCK bits;
  - group propagate P = AND of (a_i ^ bb_i);
  - group carry out = P ? carry_in : ripple carry out. This is the skip mux and must be structurally present, not synthesised away by using a behavioural '+'.
- Unprocessed upper operand bits travel down the pipeline with the transaction (input skew). Completed lower result bits are delayed to align (output deskew), so c is always coherent for one transaction.
- Stage-boundary carry is registered with the transaction.
- Flags are computed in the final stage:
  - co = carry out of group G-1;
  - ov = carry into bit N-1 XOR carry out of bit N-1;
  - zero = ~|c.
- Result is bit-exact versus (a + (sub ? ~b : b) + ci) mod 2^N, with co as bit N.
- out_valid/c/co/ov/zero are registered outputs and are held stable while out_valid=1 and out_ready=0.
- Boundary cases:
  - Full-propagate operands (a ^ bb all ones) must take the skip path through every group and stage.
  - With STAGES = N/BLOCK, each stage holds exactly one group.
  - With STAGES=1, the block is a single registered stage with latency 1.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, c=0, co=0, ov=0, zero=0. Then release rst_n with out_ready=1 -> in_ready=1.
2. Full-propagate case (N=32, BLOCK=4, STAGES=2): a=0xFFFFFFFF, b=0x00000000, ci=1, sub=0 -> exactly 2 cycles later out_valid=1, c=0x00000000, co=1, zero=1, ov=0.
3. Subtract with overflow: a=0x80000000, b=0x00000001, ci=1, sub=1 -> c=0x7FFFFFFF, co=1, ov=1, zero=0. Also a=5, b=7, sub=1, ci=1 -> c=0xFFFFFFFE, co=0, ov=0.
4. Backpressure ordering: stream 8 back-to-back transactions a=i, b=0x10*i. Drop out_ready low after the first result is observed, for 5 cycles -> outputs hold stable, in_ready=0 during the stall, then all 8 sums (0x11*i) arrive in order with no loss or duplicates.
5. Reset mid-stream: assert rst_n=0 for 1 cycle with 2 transactions in flight -> out_valid=0 on the next cycle, and neither in-flight result ever appears.
6. Parameter sweep (N=16, BLOCK=4, STAGES in {1,2,4}): 10k random a/b/ci/sub with random out_ready -> scoreboard matches the arithmetic reference model, and latency equals STAGES when unstalled.
